// File: rtl/gate_ops_pkg.sv
// Shared opcode constants and output-stage state encoding
// for the shared logic-gate scheduler.
package gate_ops_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_NOR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/gate_op_scheduler_if.sv
// Request/response bundle between clients and the scheduler.
// master = client side, slave = scheduler side.
interface gate_op_scheduler_if
    import gate_ops_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*OP_W-1:0]   req_op;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_data;
    logic [ID_W-1:0]         rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] grant_idx_o,
    output logic            any_req_o
);

    // scan N slots starting at ptr, keep the first hit
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx_o = '0;
        any_req_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            if (!any_req_o && req_i[ID_W'(idx)]) begin
                any_req_o   = 1'b1;
                grant_idx_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Shares one AND/OR/XOR/NOR unit among N_REQ requesters with
// round-robin arbitration and a one-entry registered response.
module gate_op_scheduler
    import gate_ops_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    gate_op_scheduler_if.slave bus,
    output logic [CNT_W-1:0]   op_count
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    out_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   grant_idx;
    logic              any_req;
    logic              can_accept;
    logic              fire;
    logic              rsp_hs;
    logic [DATA_W-1:0] a_sel, b_sel, gate_res;
    logic [OP_W-1:0]   op_sel;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i       (bus.req_valid),
        .ptr_i       (ptr_q),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    // accept only when the response slot is free or draining now
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;
        fire       = any_req && can_accept;
        rsp_hs     = (state_q == ST_FULL) && bus.rsp_ready;
    end

    // select the granted requester's operands and opcode
    always_comb begin
        a_sel  = bus.req_a[int'(grant_idx)*DATA_W +: DATA_W];
        b_sel  = bus.req_b[int'(grant_idx)*DATA_W +: DATA_W];
        op_sel = bus.req_op[int'(grant_idx)*OP_W +: OP_W];
    end

    // shared bitwise gate unit
    always_comb begin
        gate_res = '0;
        unique case (op_sel)
            OP_AND:  gate_res = a_sel & b_sel;
            OP_OR:   gate_res = a_sel | b_sel;
            OP_XOR:  gate_res = a_sel ^ b_sel;
            OP_NOR:  gate_res = ~(a_sel | b_sel);
            default: gate_res = '0;
        endcase
    end

    // output FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // output FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (fire) state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready && !fire) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // output FSM outputs: response valid and one-hot accept
    always_comb begin
        bus.rsp_valid = (state_q == ST_FULL);
        bus.req_ready = '0;
        if (!rst && fire) bus.req_ready[grant_idx] = 1'b1;
    end

    // next values for result, id, pointer and counter
    always_comb begin
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (fire) begin
            data_d = gate_res;
            id_d   = grant_idx;
            if (grant_idx == ID_W'(N_REQ - 1)) ptr_d = '0;
            else                               ptr_d = grant_idx + 1'b1;
        end
        if (rsp_hs) cnt_d = cnt_q + 1'b1;
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // drive registered response fields
    always_comb begin
        bus.rsp_data = data_q;
        bus.rsp_id   = id_q;
        op_count     = cnt_q;
    end

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed bench for gate_op_scheduler: arbitration order,
// opcodes, backpressure, reset and counter wrap.
module tb_gate_op_scheduler;
    import gate_ops_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] op_count;
    int         total;
    int         bad;

    gate_op_scheduler_if #(.N_REQ(4), .DATA_W(8)) bus ();

    gate_op_scheduler #(
        .N_REQ  (4),
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] op);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_op[i*2 +: 2] = op;
    endtask

    initial begin
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h30;
        exp_d[1] = 8'hFC;
        exp_d[2] = 8'hCC;
        exp_d[3] = 8'h03;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        // reset values
        tick();
        tick();
        chk("rst_rdy", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 4'h0;
        chk("rst_vld", 32'(bus.rsp_valid), 32'h0);
        chk("rst_data", 32'(bus.rsp_data), 32'h0);
        chk("rst_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_cnt", 32'(op_count), 32'h0);
        rst = 1'b0;

        // all four requesters continuously valid
        set_req(0, 8'hF0, 8'h3C, OP_AND);
        set_req(1, 8'hF0, 8'h3C, OP_OR);
        set_req(2, 8'hF0, 8'h3C, OP_XOR);
        set_req(3, 8'hF0, 8'h3C, OP_NOR);
        bus.req_valid = 4'hF;
        #1;
        chk("rr_rdy0", 32'(bus.req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_vld", 32'(bus.rsp_valid), 32'h1);
            chk("rr_id", 32'(bus.rsp_id), 32'(k % 4));
            chk("rr_data", 32'(bus.rsp_data), 32'(exp_d[k % 4]));
            chk("rr_rdy", 32'(bus.req_ready), 32'(1 << ((k + 1) % 4)));
            chk("rr_cnt", 32'(op_count), 32'(k));
        end
        bus.req_valid = 4'h0;
        tick();
        chk("rr_cnt_end", 32'(op_count), 32'd5);
        chk("rr_vld_end", 32'(bus.rsp_valid), 32'h0);

        // single request from requester 2
        set_req(2, 8'hF0, 8'h3C, OP_OR);
        bus.req_valid = 4'b0100;
        #1;
        chk("s_rdy", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'h0;
        chk("s_vld", 32'(bus.rsp_valid), 32'h1);
        chk("s_data", 32'(bus.rsp_data), 32'hFC);
        chk("s_id", 32'(bus.rsp_id), 32'h2);
        tick();
        chk("s_cnt", 32'(op_count), 32'd6);
        chk("s_vld_end", 32'(bus.rsp_valid), 32'h0);

        // backpressure: ptr is 3, requester 1 wins
        bus.rsp_ready = 1'b0;
        set_req(1, 8'hAA, 8'h55, OP_XOR);
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_rdy_acc", 32'(bus.req_ready), 32'h2);
        tick();
        set_req(0, 8'hF0, 8'h3C, OP_AND);
        set_req(2, 8'h0F, 8'hFF, OP_AND);
        set_req(3, 8'hF0, 8'h3C, OP_NOR);
        bus.req_valid = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 32'(bus.req_ready), 32'h0);
            chk("bp_vld", 32'(bus.rsp_valid), 32'h1);
            chk("bp_data", 32'(bus.rsp_data), 32'hFF);
            chk("bp_id", 32'(bus.rsp_id), 32'h1);
            tick();
        end
        chk("bp_cnt", 32'(op_count), 32'd6);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_next_rdy", 32'(bus.req_ready), 32'h4);
        tick();
        chk("bp_next_id", 32'(bus.rsp_id), 32'h2);
        chk("bp_next_data", 32'(bus.rsp_data), 32'h0F);
        chk("bp_next_cnt", 32'(op_count), 32'd7);

        // simultaneous drain and issue
        set_req(1, 8'h00, 8'h01, OP_NOR);
        bus.req_valid = 4'b0010;
        #1;
        chk("sim_rdy", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'h0;
        chk("sim_vld", 32'(bus.rsp_valid), 32'h1);
        chk("sim_data", 32'(bus.rsp_data), 32'hFE);
        chk("sim_id", 32'(bus.rsp_id), 32'h1);
        chk("sim_cnt", 32'(op_count), 32'd8);
        tick();
        chk("sim_cnt2", 32'(op_count), 32'd9);
        chk("sim_vld2", 32'(bus.rsp_valid), 32'h0);

        // reset while a result is pending
        bus.rsp_ready = 1'b0;
        set_req(0, 8'h12, 8'h34, OP_OR);
        bus.req_valid = 4'b0001;
        tick();
        chk("mr_data", 32'(bus.rsp_data), 32'h36);
        rst = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        chk("mr_rdy_in_rst", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mr_vld", 32'(bus.rsp_valid), 32'h0);
        chk("mr_cnt", 32'(op_count), 32'h0);
        chk("mr_data0", 32'(bus.rsp_data), 32'h0);
        chk("mr_rdy", 32'(bus.req_ready), 32'h0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1000;
        #1;
        chk("mr_g3_rdy", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'h0;
        chk("mr_g3_id", 32'(bus.rsp_id), 32'h3);
        chk("mr_g3_data", 32'(bus.rsp_data), 32'h03);
        tick();
        chk("mr_g3_cnt", 32'(op_count), 32'h1);

        // counter wrap with a 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 8'hFF, 8'h0F, OP_AND);
        bus.req_valid = 4'b0001;
        repeat (17) tick();
        chk("wr_cnt16", 32'(op_count), 32'h0);
        chk("wr_data", 32'(bus.rsp_data), 32'h0F);
        bus.req_valid = 4'h0;
        tick();
        chk("wr_cnt17", 32'(op_count), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
